// File: rtl/mem_arbiter_if.sv
// Requester and memory bus for the two-port memory arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          Req0;
    logic          Req1;
    logic [AW-1:0] Addr0;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WData0;
    logic [DW-1:0] WData1;
    logic          Wr0;
    logic          Wr1;
    logic          Gnt0;
    logic          Gnt1;
    logic          Ack0;
    logic          Ack1;
    logic [DW-1:0] RData;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemDout;
    logic          MemW;
    logic [DW-1:0] MemDin;
    logic          Busy;

    modport slave (
        input  Req0, Req1, Addr0, Addr1, WData0, WData1, Wr0, Wr1, MemDin,
        output Gnt0, Gnt1, Ack0, Ack1, RData, MemAddr, MemDout, MemW, Busy
    );

    modport master (
        output Req0, Req1, Addr0, Addr1, WData0, WData1, Wr0, Wr1, MemDin,
        input  Gnt0, Gnt1, Ack0, Ack1, RData, MemAddr, MemDout, MemW, Busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a synchronous memory, one transfer in flight.
// Define MEM_ARBITER_FIXED_PRIORITY_EN for fixed priority (requester 0 wins), else round-robin.
module mem_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_dout_q, mem_dout_d;
    logic          mem_w_q, mem_w_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          winner;

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        winner = ~bus.Req0;
    end
`else
    logic last_q, last_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (bus.Req0 && bus.Req1) begin
            winner = ~last_q;
        end else begin
            winner = bus.Req1 & ~bus.Req0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        mem_w_d    = mem_w_q;
        rdata_d    = rdata_q;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.Req0 || bus.Req1) begin
                    owner_d    = winner;
                    mem_addr_d = winner ? bus.Addr1 : bus.Addr0;
                    mem_dout_d = winner ? bus.WData1 : bus.WData0;
                    mem_w_d    = winner ? bus.Wr1 : bus.Wr0;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
                    last_d     = winner;
`endif
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                mem_w_d = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                // Memory output for the captured address is valid here.
                rdata_d = bus.MemDin;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            mem_w_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            mem_w_q    <= mem_w_d;
            rdata_q    <= rdata_d;
        end
    end

    // Strobes decode from registered state so reset clears them immediately.
    assign bus.Gnt0    = (state_q == StIssue) && !owner_q;
    assign bus.Gnt1    = (state_q == StIssue) && owner_q;
    assign bus.Ack0    = (state_q == StResp) && !owner_q;
    assign bus.Ack1    = (state_q == StResp) && owner_q;
    assign bus.Busy    = (state_q != StIdle);
    assign bus.RData   = rdata_q;
    assign bus.MemAddr = mem_addr_q;
    assign bus.MemDout = mem_dout_q;
    assign bus.MemW    = mem_w_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transfers plus tie, drop and reset cases.
module tb_mem_arbiter;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    // Synchronous memory with a side port for preloading.
    logic [15:0] mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge Clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.MemW) mem[bus.MemAddr] <= bus.MemDout;
        bus.MemDin <= mem[bus.MemAddr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          who;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          chk_rd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    // Called just after a negedge with the arbiter idle.
    task automatic do_xfer(input bit who, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit chk_rd,
                           input logic [15:0] exp_rd);
        if (!who) begin
            bus.Req0 = 1'b1; bus.Wr0 = wr; bus.Addr0 = addr; bus.WData0 = wdata;
        end else begin
            bus.Req1 = 1'b1; bus.Wr1 = wr; bus.Addr1 = addr; bus.WData1 = wdata;
        end
        @(negedge Clock);
        chk("gnt_own", 32'(who ? bus.Gnt1 : bus.Gnt0), 1);
        chk("gnt_other", 32'(who ? bus.Gnt0 : bus.Gnt1), 0);
        chk("issue_addr", 32'(bus.MemAddr), 32'(addr));
        chk("issue_memw", 32'(bus.MemW), 32'(wr));
        if (wr) chk("issue_dout", 32'(bus.MemDout), 32'(wdata));
        chk("issue_busy", 32'(bus.Busy), 1);
        @(negedge Clock);
        chk("wait_memw", 32'(bus.MemW), 0);
        chk("wait_gnt", 32'(bus.Gnt0 | bus.Gnt1), 0);
        chk("wait_ack", 32'(bus.Ack0 | bus.Ack1), 0);
        @(negedge Clock);
        chk("ack_own", 32'(who ? bus.Ack1 : bus.Ack0), 1);
        chk("ack_other", 32'(who ? bus.Ack0 : bus.Ack1), 0);
        if (chk_rd) chk("rdata", 32'(bus.RData), 32'(exp_rd));
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        @(negedge Clock);
        chk("idle_busy", 32'(bus.Busy), 0);
        chk("idle_ack", 32'(bus.Ack0 | bus.Ack1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int ngnt;
    bit gseq [8];
    bit exp_owner;
    bit got;

    initial begin
        vecs[0] = '{who: 1'b0, wr: 1'b0, addr: 16'h0010, wdata: 16'h0000, chk_rd: 1'b1, exp_rd: 16'hBEEF};
        vecs[1] = '{who: 1'b1, wr: 1'b1, addr: 16'h0020, wdata: 16'h1234, chk_rd: 1'b0, exp_rd: 16'h0000};
        vecs[2] = '{who: 1'b0, wr: 1'b0, addr: 16'h0020, wdata: 16'h0000, chk_rd: 1'b1, exp_rd: 16'h1234};
        vecs[3] = '{who: 1'b1, wr: 1'b0, addr: 16'h0010, wdata: 16'h0000, chk_rd: 1'b1, exp_rd: 16'hBEEF};
        vecs[4] = '{who: 1'b0, wr: 1'b1, addr: 16'h00FF, wdata: 16'hA5A5, chk_rd: 1'b0, exp_rd: 16'h0000};
        vecs[5] = '{who: 1'b1, wr: 1'b0, addr: 16'h00FF, wdata: 16'h0000, chk_rd: 1'b1, exp_rd: 16'hA5A5};
        vecs[6] = '{who: 1'b1, wr: 1'b1, addr: 16'hFFFF, wdata: 16'h0F0F, chk_rd: 1'b0, exp_rd: 16'h0000};
        vecs[7] = '{who: 1'b0, wr: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, chk_rd: 1'b1, exp_rd: 16'h0F0F};

        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.Wr0 = 1'b0;  bus.Wr1 = 1'b0;
        bus.Addr0 = '0;  bus.Addr1 = '0;
        bus.WData0 = '0; bus.WData1 = '0;

        // Reset state
        #12;
        chk("rst_busy", 32'(bus.Busy), 0);
        chk("rst_memw", 32'(bus.MemW), 0);
        chk("rst_memaddr", 32'(bus.MemAddr), 0);
        chk("rst_memdout", 32'(bus.MemDout), 0);
        chk("rst_rdata", 32'(bus.RData), 0);
        chk("rst_gnt", 32'(bus.Gnt0 | bus.Gnt1), 0);
        chk("rst_ack", 32'(bus.Ack0 | bus.Ack1), 0);
        @(negedge Clock);
        Resetn = 1'b1;

        pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 16'hBEEF;
        @(negedge Clock);
        pre_we = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].chk_rd, vecs[i].exp_rd);
        end

        // Request dropped and inputs changed after capture
        bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 16'h0010;
        @(negedge Clock);
        chk("drop_gnt0", 32'(bus.Gnt0), 1);
        chk("drop_issue_addr", 32'(bus.MemAddr), 32'h0010);
        bus.Req0 = 1'b0; bus.Addr0 = 16'hFFFF; bus.Wr0 = 1'b1; bus.WData0 = 16'h5555;
        @(negedge Clock);
        chk("drop_wait_addr", 32'(bus.MemAddr), 32'h0010);
        chk("drop_wait_memw", 32'(bus.MemW), 0);
        @(negedge Clock);
        chk("drop_ack0", 32'(bus.Ack0), 1);
        chk("drop_rdata", 32'(bus.RData), 32'hBEEF);
        chk("drop_resp_addr", 32'(bus.MemAddr), 32'h0010);
        @(negedge Clock);
        chk("drop_idle", 32'(bus.Busy), 0);
        bus.Wr0 = 1'b0;

        // Simultaneous requests held for 16 cycles, fresh from reset
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        bus.Addr0 = 16'h0010; bus.Addr1 = 16'h0020; bus.Wr0 = 1'b0; bus.Wr1 = 1'b0;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        ngnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge Clock);
            chk("tie_gnt_excl", 32'(bus.Gnt0 & bus.Gnt1), 0);
            chk("tie_ack_excl", 32'(bus.Ack0 & bus.Ack1), 0);
            if (bus.Gnt0 || bus.Gnt1) begin
                if (ngnt < 8) gseq[ngnt] = bus.Gnt1;
                ngnt++;
            end
        end
        chk("tie_count", 32'(ngnt), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
            exp_owner = 1'b0;
`else
            exp_owner = (i % 2) == 1;
`endif
            chk("tie_order", 32'(gseq[i]), 32'(exp_owner));
        end
        bus.Req0 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge Clock);
            if (bus.Gnt1) got = 1'b1;
        end
        chk("req1_after_drop", 32'(got), 1);
        bus.Req1 = 1'b0;
        repeat (3) @(negedge Clock);
        chk("req1_idle", 32'(bus.Busy), 0);

        // Reset during WAIT of a write
        bus.Req1 = 1'b1; bus.Wr1 = 1'b1; bus.Addr1 = 16'h0030; bus.WData1 = 16'h7777;
        @(negedge Clock);
        chk("rstw_issue_memw", 32'(bus.MemW), 1);
        bus.Req1 = 1'b0; bus.Wr1 = 1'b0;
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        chk("rstw_memw", 32'(bus.MemW), 0);
        chk("rstw_busy", 32'(bus.Busy), 0);
        chk("rstw_gnt", 32'(bus.Gnt0 | bus.Gnt1), 0);
        chk("rstw_ack", 32'(bus.Ack0 | bus.Ack1), 0);
        chk("rstw_memaddr", 32'(bus.MemAddr), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            chk("rstw_no_ack", 32'(bus.Ack0 | bus.Ack1), 0);
            chk("rstw_idle", 32'(bus.Busy), 0);
        end
        // The write strobe fired in ISSUE, before the reset.
        do_xfer(1'b0, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, address width in bits.
REQ-002 Parameter DW, default 16, data width in bits.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Req0, Req1  input  1 each  access request from requester 0 and requester 1; level, held until Ack.
REQ-006 Addr0, Addr1  input  AW each  word address of the request.
REQ-007 WData0, WData1  input  DW each  write data.
REQ-008 Wr0, Wr1  input  1 each  1 = write, 0 = read.
REQ-009 Gnt0, Gnt1  output  1 each  one-cycle pulse: request accepted.
REQ-010 Ack0, Ack1  output  1 each  one-cycle pulse: transfer complete; RData valid for reads.
REQ-011 RData  output  DW  read data, shared by both requesters.
REQ-012 MemAddr  output  AW  synchronous-memory address, registered.
REQ-013 MemDout  output  DW  synchronous-memory write data, registered.
REQ-014 MemW  output  1  synchronous-memory write enable, registered.
REQ-015 MemDin  input  DW  synchronous-memory read data, valid one cycle after address capture.
REQ-016 Busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, and SHALL hold at most one transfer in flight.
REQ-018 IDLE: if Req0 or Req1 is high, the arbiter SHALL choose a winner, register its Addr/WData/Wr into MemAddr/MemDout/MemW, record Owner, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 ISSUE: Gnt[Owner] SHALL be 1 for exactly this cycle, and the state SHALL go to WAIT.
REQ-020 WAIT: MemW SHALL be 0 (write strobe is exactly one cycle, in ISSUE), and the state SHALL go to RESP.
REQ-021 RESP: Ack[Owner] SHALL be 1 for exactly this cycle, RData SHALL equal MemDin, and the state SHALL go to IDLE.
REQ-022 Latency: with Req sampled at edge N, Gnt SHALL be high in cycle N+1 and Ack in cycle N+3; a requester that holds Req continuously SHALL see at most one transfer per 4 cycles.
REQ-023 Round-robin: a Last register SHALL hold the most recent Owner; on a simultaneous request the requester other than Last SHALL win; Last SHALL update only in IDLE-to-ISSUE transitions.
REQ-024 With a single request, that requester SHALL win regardless of Last.
REQ-025 A request dropped after capture SHALL NOT abort the transfer; the memory access and Ack SHALL still occur.
REQ-026 Changes to Addr/WData/Wr after capture SHALL NOT affect the transfer in flight.
REQ-027 Gnt0 and Gnt1 SHALL never both be 1; the same SHALL hold for Ack0 and Ack1.
REQ-028 Outside RESP, RData SHALL hold its last value; it SHALL be registered on entry to RESP from MemDin.
REQ-029 Write transfers SHALL follow the same state path and produce an Ack; RData content on a write Ack is don't-care.

Reset
REQ-030 Resetn low SHALL immediately force: state IDLE, Last = 1 (requester 0 wins the first tie), Owner 0, MemAddr 0, MemDout 0, MemW 0, RData 0, Gnt/Ack 0, Busy 0.
REQ-031 A reset during ISSUE/WAIT/RESP SHALL abandon the transfer with no Ack; MemW SHALL fall asynchronously.

Configuration
REQ-032 Macro MEM_ARBITER_FIXED_PRIORITY_EN: when defined, requester 0 SHALL always win simultaneous requests and the Last register SHALL be omitted; when undefined, the round-robin of REQ-023 SHALL apply.

Verification
REQ-033 Reset, then Req0 read Addr0=0x0010 with memory[0x0010]=0xBEEF -> Gnt0 at N+1, MemW=0, Ack0 at N+3 with RData=0xBEEF.
REQ-034 Req1 write Addr1=0x0020, WData1=0x1234 -> MemW=1 for exactly one cycle with MemAddr=0x0020 and MemDout=0x1234; Ack1 at N+3; subsequent read of 0x0020 returns 0x1234.
REQ-035 Req0 and Req1 held high for 16 cycles (round-robin build) -> grants alternate 0,1,0,1; first grant to 0; 4 grants total; Gnt and Ack never both-high across requesters.
REQ-036 Same stimulus with MEM_ARBITER_FIXED_PRIORITY_EN defined -> all 4 grants go to requester 0; requester 1 granted only after Req0 drops.
REQ-037 Req0 read captured, then Req0 dropped and Addr0 changed to 0xFFFF in ISSUE -> MemAddr stays 0x0010 and Ack0 still pulses at N+3.
REQ-038 Resetn pulsed low during WAIT of a write -> MemW, Busy, Gnt and Ack go 0 immediately, no Ack follows, and the next request is served normally.
